// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the memory/writeback stage.
// Holds writeback-select encodings, load funct3 codes and the stage FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_wb_stage_pkg;

    // Writeback source select; 2'b11 is routed like the ALU result.
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    // Load width/sign codes carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } state_t;

    // x0 is hardwired to zero, so a write to it is suppressed.
    function automatic logic rf_write_en(input logic reg_write, input logic [4:0] rd);
        return reg_write && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data aligner: selects byte/half/word from the memory word and extends it.
// Purely combinational, zero latency.
// No flow control; misaligned accesses still produce data and raise misaligned_o.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half; half ignores the low offset bit.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend per load type; unknown funct3 codes behave as a word load.
    always_comb begin
        data_o       = rdata_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {24'd0, byte_sel};
            F3_LH: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = off_i[0];
            end
            F3_LHU: begin
                data_o       = {16'd0, half_sel};
                misaligned_o = off_i[0];
            end
            F3_LW: begin
                data_o       = rdata_i;
                misaligned_o = (off_i != 2'd0);
            end
            default: begin
                data_o       = rdata_i;
                misaligned_o = (off_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires one instruction per cycle, waits for load data, drives the RF write port.
// Latency: 1 cycle transfer->wb_we for non-loads; loads retire 1 cycle after the mem_rvalid cycle.
// Backpressure: in_ready drops while a load is outstanding; a silent memory forces an error retire after LOAD_TIMEOUT cycles.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_wb_sel,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic        wb_err,
    output logic [31:0] retire_count
);

    // Counter only needs to hold 0..LOAD_TIMEOUT-1 waiting cycles.
    localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    state_t state_q, state_d;

    logic [4:0]       ld_rd_q, ld_rd_d;
    logic             ld_we_q, ld_we_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_off_q, ld_off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_err_q, wb_err_d;
    logic [31:0] retire_q, retire_d;

    logic        accept;
    logic        alu_fire;
    logic        load_fire;
    logic        load_done;
    logic        load_timeout;
    logic [31:0] align_data;
    logic        align_misaligned;

    mem_wb_stage_load_align u_align (
        .funct3_i     (ld_f3_q),
        .off_i        (ld_off_q),
        .rdata_i      (mem_rdata),
        .data_o       (align_data),
        .misaligned_o (align_misaligned)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a load parks the stage until data arrives or the wait expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (load_fire) state_d = ST_WAIT_LOAD;
            ST_WAIT_LOAD: if (load_done || load_timeout) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and retire qualifiers; mem_rvalid in IDLE has no effect.
    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        accept       = in_valid && in_ready;
        alu_fire     = accept && (in_wb_sel != WB_LOAD);
        load_fire    = accept && (in_wb_sel == WB_LOAD);
        load_done    = (state_q == ST_WAIT_LOAD) && mem_rvalid;
        load_timeout = (state_q == ST_WAIT_LOAD) && !mem_rvalid && (cnt_q == CNT_LAST);
    end

    // Datapath next state: latch pending load, build writeback, count retires.
    always_comb begin
        ld_rd_d   = ld_rd_q;
        ld_we_d   = ld_we_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        cnt_d     = cnt_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_we_d   = 1'b0;
        wb_err_d  = 1'b0;
        retire_d  = retire_q;

        if (alu_fire) begin
            wb_rd_d = in_rd;
            case (in_wb_sel)
                WB_ALU:  wb_data_d = in_alu_result;
                WB_PC4:  wb_data_d = in_pc_plus4;
                default: wb_data_d = in_alu_result;
            endcase
            wb_we_d  = rf_write_en(in_reg_write, in_rd);
            retire_d = retire_q + 32'd1;
        end

        if (load_fire) begin
            ld_rd_d  = in_rd;
            ld_we_d  = in_reg_write;
            ld_f3_d  = in_funct3;
            ld_off_d = in_alu_result[1:0];
            cnt_d    = '0;
        end

        if (load_done) begin
            wb_rd_d   = ld_rd_q;
            wb_data_d = align_data;
            wb_we_d   = rf_write_en(ld_we_q, ld_rd_q);
            wb_err_d  = align_misaligned;
            retire_d  = retire_q + 32'd1;
        end else if (load_timeout) begin
            wb_rd_d   = ld_rd_q;
            wb_data_d = 32'd0;
            wb_err_d  = 1'b1;
            retire_d  = retire_q + 32'd1;
        end else if (state_q == ST_WAIT_LOAD) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers; reset drops any pending load without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_rd_q   <= 5'd0;
            ld_we_q   <= 1'b0;
            ld_f3_q   <= 3'd0;
            ld_off_q  <= 2'd0;
            cnt_q     <= '0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
            wb_we_q   <= 1'b0;
            wb_err_q  <= 1'b0;
            retire_q  <= 32'd0;
        end else begin
            ld_rd_q   <= ld_rd_d;
            ld_we_q   <= ld_we_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
            cnt_q     <= cnt_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            wb_err_q  <= wb_err_d;
            retire_q  <= retire_d;
        end
    end

    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_we        = wb_we_q;
    assign wb_err       = wb_err_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU/PC+4 writeback, load alignment, timeout, x0, reset mid-load.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the capturing rise.
// Expected values are hand-computed constants plus a bench-side retire counter.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_err;
    logic [31:0] retire_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    mem_wb_stage #(.LOAD_TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_we         (wb_we),
        .wb_err        (wb_err),
        .retire_count  (retire_count)
    );

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0; in_wb_sel = 2'b00;
        in_funct3 = 3'b000; in_alu_result = 32'd0; in_pc_plus4 = 32'd0;
        mem_rdata = 32'd0; mem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (wb_we !== 1'b0) $display("FAIL reset_wb_we: got %b expected 0", wb_we); else pass_cnt++;
        total_cnt++; if (wb_err !== 1'b0) $display("FAIL reset_wb_err: got %b expected 0", wb_err); else pass_cnt++;
        total_cnt++; if (wb_rd !== 5'd0) $display("FAIL reset_wb_rd: got %0d expected 0", wb_rd); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data: got %h expected 0", wb_data); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", retire_count); else pass_cnt++;
        exp_count = 32'd0;
    endtask

    task automatic test_alu;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd5; in_reg_write = 1'b1; in_wb_sel = 2'b00;
        in_alu_result = 32'h0000_1234; in_pc_plus4 = 32'h0000_0444;
        @(negedge clk);
        in_valid = 1'b0;
        exp_count++;
        total_cnt++; if (wb_we !== 1'b1) $display("FAIL alu_we: got %b expected 1", wb_we); else pass_cnt++;
        total_cnt++; if (wb_rd !== 5'd5) $display("FAIL alu_rd: got %0d expected 5", wb_rd); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h0000_1234) $display("FAIL alu_data: got %h expected 00001234", wb_data); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL alu_count: got %0d expected %0d", retire_count, exp_count); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (wb_we !== 1'b0) $display("FAIL alu_we_pulse: got %b expected 0", wb_we); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h0000_1234) $display("FAIL alu_data_hold: got %h expected 00001234", wb_data); else pass_cnt++;
    endtask

    task automatic test_wb_sel;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd1; in_reg_write = 1'b1; in_wb_sel = 2'b10;
        in_alu_result = 32'hDEAD_BEEF; in_pc_plus4 = 32'h0000_0100;
        @(negedge clk);
        in_wb_sel = 2'b11; in_rd = 5'd2; in_alu_result = 32'h1357_9BDF;
        exp_count++;
        total_cnt++; if (wb_data !== 32'h0000_0100) $display("FAIL pc4_data: got %h expected 00000100", wb_data); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0; in_wb_sel = 2'b00;
        exp_count++;
        total_cnt++; if (wb_data !== 32'h1357_9BDF) $display("FAIL sel11_data: got %h expected 13579bdf", wb_data); else pass_cnt++;
        total_cnt++; if (wb_rd !== 5'd2) $display("FAIL sel11_rd: got %0d expected 2", wb_rd); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL sel_count: got %0d expected %0d", retire_count, exp_count); else pass_cnt++;
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] rdata, input int delay,
                           input logic [31:0] exp_data, input logic exp_err);
        logic [29:0] base;
        base = 30'h0000_0400;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd7; in_reg_write = 1'b1; in_wb_sel = 2'b01;
        in_funct3 = f3; in_alu_result = {base, off};
        @(negedge clk);
        in_valid = 1'b0; in_wb_sel = 2'b00;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL %s_busy: got in_ready %b expected 0", name, in_ready); else pass_cnt++;
        for (int i = 1; i < delay; i++) @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL %s_rvalid_cycle_ready: got %b expected 0", name, in_ready); else pass_cnt++;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        exp_count++;
        total_cnt++; if (wb_data !== exp_data) $display("FAIL %s_data: got %h expected %h", name, wb_data, exp_data); else pass_cnt++;
        total_cnt++; if (wb_we !== 1'b1) $display("FAIL %s_we: got %b expected 1", name, wb_we); else pass_cnt++;
        total_cnt++; if (wb_err !== exp_err) $display("FAIL %s_err: got %b expected %b", name, wb_err, exp_err); else pass_cnt++;
        total_cnt++; if (wb_rd !== 5'd7) $display("FAIL %s_rd: got %0d expected 7", name, wb_rd); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL %s_count: got %0d expected %0d", name, retire_count, exp_count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL %s_ready_after: got %b expected 1", name, in_ready); else pass_cnt++;
    endtask

    task automatic test_loads;
        do_load("lb",   3'b000, 2'd3, 32'h80FF_0000, 2, 32'hFFFF_FF80, 1'b0);
        do_load("lbu",  3'b100, 2'd3, 32'h80FF_0000, 2, 32'h0000_0080, 1'b0);
        do_load("lh",   3'b001, 2'd2, 32'h8001_0000, 2, 32'hFFFF_8001, 1'b0);
        do_load("lhu",  3'b101, 2'd1, 32'h8001_0000, 2, 32'h0000_0000, 1'b1);
        do_load("lw",   3'b010, 2'd0, 32'hCAFE_BABE, 1, 32'hCAFE_BABE, 1'b0);
        do_load("lwmis",3'b010, 2'd2, 32'hCAFE_BABE, 3, 32'hCAFE_BABE, 1'b1);
        do_load("lb1",  3'b000, 2'd1, 32'h0000_7F00, 1, 32'h0000_007F, 1'b0);
        do_load("ill",  3'b111, 2'd0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_timeout;
        logic early_err;
        early_err = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd9; in_reg_write = 1'b1; in_wb_sel = 2'b01;
        in_funct3 = 3'b010; in_alu_result = 32'h0000_2000;
        @(negedge clk);
        in_valid = 1'b0; in_wb_sel = 2'b00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (wb_err !== 1'b0 || in_ready !== 1'b0) early_err = 1'b1;
        end
        total_cnt++; if (early_err !== 1'b0) $display("FAIL to_early: retired before 15 cycles (flag %b) expected 0", early_err); else pass_cnt++;
        @(negedge clk);
        exp_count++;
        total_cnt++; if (wb_err !== 1'b1) $display("FAIL to_err: got %b expected 1", wb_err); else pass_cnt++;
        total_cnt++; if (wb_we !== 1'b0) $display("FAIL to_we: got %b expected 0", wb_we); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'd0) $display("FAIL to_data: got %h expected 0", wb_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL to_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL to_count: got %0d expected %0d", retire_count, exp_count); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (wb_err !== 1'b0) $display("FAIL to_err_pulse: got %b expected 0", wb_err); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd0; in_reg_write = 1'b1; in_wb_sel = 2'b00;
        in_alu_result = 32'h0000_0055;
        @(negedge clk);
        in_rd = 5'd31; in_alu_result = 32'h0000_0077;
        exp_count++;
        total_cnt++; if (wb_we !== 1'b0) $display("FAIL b2b_rd0_we: got %b expected 0", wb_we); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL b2b_count1: got %0d expected %0d", retire_count, exp_count); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        exp_count++;
        total_cnt++; if (wb_we !== 1'b1) $display("FAIL b2b_rd31_we: got %b expected 1", wb_we); else pass_cnt++;
        total_cnt++; if (wb_rd !== 5'd31) $display("FAIL b2b_rd31_rd: got %0d expected 31", wb_rd); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'h0000_0077) $display("FAIL b2b_rd31_data: got %h expected 00000077", wb_data); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL b2b_count2: got %0d expected %0d", retire_count, exp_count); else pass_cnt++;
        // reg_write=0 still retires but never writes
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd3; in_reg_write = 1'b0; in_alu_result = 32'h0000_0011;
        @(negedge clk);
        in_valid = 1'b0;
        exp_count++;
        total_cnt++; if (wb_we !== 1'b0) $display("FAIL nowrite_we: got %b expected 0", wb_we); else pass_cnt++;
        total_cnt++; if (retire_count !== exp_count) $display("FAIL nowrite_count: got %0d expected %0d", retire_count, exp_count); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd12; in_reg_write = 1'b1; in_wb_sel = 2'b01;
        in_funct3 = 3'b010; in_alu_result = 32'h0000_3000;
        @(negedge clk);
        in_valid = 1'b0; in_wb_sel = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        exp_count = 32'd0;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        total_cnt++; if (wb_we !== 1'b0) $display("FAIL rst_mid_we: got %b expected 0", wb_we); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'd0) $display("FAIL rst_mid_count: got %0d expected 0", retire_count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", in_ready); else pass_cnt++;
        total_cnt++; if (wb_data !== 32'd0) $display("FAIL rst_mid_data: got %h expected 0", wb_data); else pass_cnt++;
        // stage must still work normally after the aborted load
        in_valid = 1'b1; in_rd = 5'd4; in_reg_write = 1'b1; in_wb_sel = 2'b00; in_alu_result = 32'h0000_0ABC;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++; if (wb_data !== 32'h0000_0ABC || wb_we !== 1'b1) $display("FAIL rst_mid_after: got data %h we %b expected 00000abc/1", wb_data, wb_we); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'd1) $display("FAIL rst_mid_after_count: got %0d expected 1", retire_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_wb_sel();
        test_loads();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
